regfile_wp_arbiter: RTL and testbench

// - Shares the register file's single result write port (WP1_*) among NREQ producers (ROB commit, LSU, ALU, branch).
// - Round-robin arbitration with a per-requester starvation guard; registered output drives RegFile WP1_* directly.
// - ROB_FLUSH_Flag squashes the in-flight grant and all wait counters.

---
 rtl/regfile_wp_arbiter.sv | 166 ++++++++++++++++
 tb/tb_regfile_wp_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wp_arbiter.sv
// regfile_wp_arbiter
// Lets NREQ producers (ROB commit, LSU, ALU, branch) share the RegFile result
// write port WP1_*. Round-robin arbitration, with a per-requester wait counter
// that forces a grant once a requester has lost MAX_WAIT times in a row.
// A flush squashes the current grant and clears every wait counter.
// Optional macro REGFILE_WP_BYPASS_EN: when exactly one requester is valid and
// nothing is pending, WP1_* follows that requester combinationally (0-cycle path).
module regfile_wp_arbiter #(
  parameter int NREQ     = 4,
  parameter int ROBEN_W  = 5,
  parameter int MAX_WAIT = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ROB_FLUSH_Flag,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*5-1:0]       req_DRindex,
  input  logic [NREQ*ROBEN_W-1:0] req_ROBEN,
  input  logic [NREQ*32-1:0]      req_Data,
  output logic                    WP1_Wen,
  output logic [4:0]              WP1_DRindex,
  output logic [ROBEN_W-1:0]      WP1_ROBEN,
  output logic [31:0]             WP1_Data,
  output logic                    starve_flag
);

  localparam int DATA_W = 32;
  localparam int DR_W   = 5;
  localparam int PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W  = 8;

  // Wait counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Registered state
  logic [PTR_W-1:0]   rr_ptr_p1;
  logic [CNT_W-1:0]   wait_cnt_p1 [NREQ];
  logic               vld_p1;
  logic               starve_p1;
  logic [DR_W-1:0]    dr_p1;
  logic [ROBEN_W-1:0] roben_p1;
  logic [DATA_W-1:0]  data_p1;

  // Arbitration-cycle signals
  logic [NREQ-1:0]    forced_p0;
  logic               vld_p0;
  logic [PTR_W-1:0]   gnt_idx_p0;
  logic [PTR_W-1:0]   rr_idx_p0;
  logic [NREQ-1:0]    gnt_p0;
  logic               gnt_forced_p0;
  logic [DR_W-1:0]    dr_p0;
  logic [ROBEN_W-1:0] roben_p0;
  logic [DATA_W-1:0]  data_p0;
  logic               wen_p0;
  logic               byp_p0;

  // ---- stage p0: arbitration ----

  // Starvation guard: a valid requester that has lost MAX_WAIT times is forced.
  always_comb begin
    forced_p0 = '0;
    for (int i = 0; i < NREQ; i++)
      forced_p0[i] = req_valid[i] && (wait_cnt_p1[i] >= CNT_W'(MAX_WAIT));
  end

  // Winner: lowest-index forced requester first, otherwise round robin from rr_ptr.
  always_comb begin
    vld_p0     = 1'b0;
    gnt_idx_p0 = '0;
    rr_idx_p0  = '0;
    if (!rst && !ROB_FLUSH_Flag) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!vld_p0 && forced_p0[i]) begin
          vld_p0     = 1'b1;
          gnt_idx_p0 = PTR_W'(i);
        end
      end
      for (int k = 0; k < NREQ; k++) begin
        rr_idx_p0 = PTR_W'((int'(rr_ptr_p1) + k) % NREQ);
        if (!vld_p0 && req_valid[rr_idx_p0]) begin
          vld_p0     = 1'b1;
          gnt_idx_p0 = rr_idx_p0;
        end
      end
    end
  end

  // Mux the winner's fields; a zero destination or zero tag is consumed without a write.
  always_comb begin
    dr_p0    = '0;
    roben_p0 = '0;
    data_p0  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx_p0 == PTR_W'(i)) begin
        dr_p0    = req_DRindex[i*DR_W +: DR_W];
        roben_p0 = req_ROBEN[i*ROBEN_W +: ROBEN_W];
        data_p0  = req_Data[i*DATA_W +: DATA_W];
      end
    end
    gnt_p0 = '0;
    if (vld_p0)
      gnt_p0[gnt_idx_p0] = 1'b1;
    gnt_forced_p0 = vld_p0 && forced_p0[gnt_idx_p0];
    wen_p0        = vld_p0 && (dr_p0 != '0) && (roben_p0 != '0);
  end

  assign req_ready = gnt_p0;

`ifdef REGFILE_WP_BYPASS_EN
  assign byp_p0 = $onehot(req_valid) && !ROB_FLUSH_Flag && !vld_p1 && !rst;
`else
  assign byp_p0 = 1'b0;
`endif

  // ---- stage p1: output register, round-robin pointer and wait counters ----

  // Capture the winner; a bypassed transfer loads the fields but not the enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_p1 <= '0;
      vld_p1    <= 1'b0;
      starve_p1 <= 1'b0;
      dr_p1     <= '0;
      roben_p1  <= '0;
      data_p1   <= '0;
      for (int i = 0; i < NREQ; i++)
        wait_cnt_p1[i] <= '0;
    end else if (ROB_FLUSH_Flag) begin
      vld_p1    <= 1'b0;
      starve_p1 <= 1'b0;
      for (int i = 0; i < NREQ; i++)
        wait_cnt_p1[i] <= '0;
    end else begin
      vld_p1    <= wen_p0 && !byp_p0;
      starve_p1 <= gnt_forced_p0;
      if (vld_p0) begin
        dr_p1     <= dr_p0;
        roben_p1  <= roben_p0;
        data_p1   <= data_p0;
        rr_ptr_p1 <= (gnt_idx_p0 == PTR_W'(NREQ-1)) ? '0 : gnt_idx_p0 + 1'b1;
      end
      for (int i = 0; i < NREQ; i++)
        wait_cnt_p1[i] <= (req_valid[i] && !gnt_p0[i]) ? sat_inc(wait_cnt_p1[i]) : '0;
    end
  end

  // Drive the write port from the register, or from the bypass path when it is active.
  always_comb begin
    WP1_Wen     = vld_p1;
    WP1_DRindex = dr_p1;
    WP1_ROBEN   = roben_p1;
    WP1_Data    = data_p1;
    if (byp_p0) begin
      WP1_Wen     = wen_p0;
      WP1_DRindex = dr_p0;
      WP1_ROBEN   = roben_p0;
      WP1_Data    = data_p0;
    end
  end

  assign starve_flag = starve_p1;

endmodule

// File: tb/tb_regfile_wp_arbiter.sv
// Bench for regfile_wp_arbiter: two instances share the stimulus, one with the
// default MAX_WAIT and one with MAX_WAIT = 2 so that forced grants appear often.
// A reference model predicts grants, starve_flag and the write stream; predicted
// writes are queued and a separate monitor checks them as the DUT presents them.
module tb_regfile_wp_arbiter;
  localparam int NREQ    = 4;
  localparam int ROBEN_W = 5;
  localparam int MW0     = 7;
  localparam int MW1     = 2;

  typedef struct {
    int                 inst;
    int                 cyc;
    logic [4:0]         dr;
    logic [ROBEN_W-1:0] rob;
    logic [31:0]        data;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    flush;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*5-1:0]       req_DRindex;
  logic [NREQ*ROBEN_W-1:0] req_ROBEN;
  logic [NREQ*32-1:0]      req_Data;
  logic [NREQ-1:0]         ready [2];
  logic                    wen [2];
  logic [4:0]              wdr [2];
  logic [ROBEN_W-1:0]      wrob [2];
  logic [31:0]             wdata [2];
  logic                    starve [2];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t eq[$];
  int   m_rr [2];
  int   m_wait [2][NREQ];
  bit   m_wen_reg [2];
  bit   m_starve [2];
  logic [3:0] seq_s [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b0001};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  regfile_wp_arbiter #(.NREQ(NREQ), .ROBEN_W(ROBEN_W), .MAX_WAIT(MW0)) dut (
    .clk(clk), .rst(rst), .ROB_FLUSH_Flag(flush),
    .req_valid(req_valid), .req_ready(ready[0]),
    .req_DRindex(req_DRindex), .req_ROBEN(req_ROBEN), .req_Data(req_Data),
    .WP1_Wen(wen[0]), .WP1_DRindex(wdr[0]), .WP1_ROBEN(wrob[0]), .WP1_Data(wdata[0]),
    .starve_flag(starve[0])
  );

  regfile_wp_arbiter #(.NREQ(NREQ), .ROBEN_W(ROBEN_W), .MAX_WAIT(MW1)) dut_s (
    .clk(clk), .rst(rst), .ROB_FLUSH_Flag(flush),
    .req_valid(req_valid), .req_ready(ready[1]),
    .req_DRindex(req_DRindex), .req_ROBEN(req_ROBEN), .req_Data(req_Data),
    .WP1_Wen(wen[1]), .WP1_DRindex(wdr[1]), .WP1_ROBEN(wrob[1]), .WP1_Data(wdata[1]),
    .starve_flag(starve[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_req(input int i, input logic [4:0] dr, input logic [ROBEN_W-1:0] rob,
                         input logic [31:0] data);
    req_DRindex[i*5 +: 5]             = dr;
    req_ROBEN[i*ROBEN_W +: ROBEN_W]   = rob;
    req_Data[i*32 +: 32]              = data;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_rr[k]      = 0;
      m_wen_reg[k] = 1'b0;
      m_starve[k]  = 1'b0;
      for (int i = 0; i < NREQ; i++) m_wait[k][i] = 0;
    end
    eq.delete();
  endtask

  // One cycle of the reference model for instance k, using the inputs now applied.
  task automatic model_step(input int k);
    int                 g;
    int                 j;
    int                 mw;
    bit                 f;
    bit                 byp;
    logic [4:0]         dr;
    logic [ROBEN_W-1:0] rb;
    logic [31:0]        d;
    mw  = (k == 0) ? MW0 : MW1;
    g   = -1;
    f   = 1'b0;
    byp = 1'b0;
    dr  = '0;
    rb  = '0;
    d   = '0;
    chk($sformatf("starve_flag[%0d]", k), 32'(starve[k]), 32'(m_starve[k]));
    if (!flush) begin
      for (int i = 0; i < NREQ; i++)
        if (g < 0 && req_valid[i] && m_wait[k][i] >= mw) g = i;
      f = (g >= 0);
      for (int s = 0; s < NREQ; s++) begin
        j = (m_rr[k] + s) % NREQ;
        if (g < 0 && req_valid[j]) g = j;
      end
    end
    chk($sformatf("req_ready[%0d]", k), 32'(ready[k]), (g < 0) ? 32'd0 : (32'd1 << g));
`ifdef REGFILE_WP_BYPASS_EN
    byp = ($countones(req_valid) == 1) && !flush && !m_wen_reg[k];
`endif
    if (g >= 0) begin
      dr = req_DRindex[g*5 +: 5];
      rb = req_ROBEN[g*ROBEN_W +: ROBEN_W];
      d  = req_Data[g*32 +: 32];
      if (dr != 0 && rb != 0) eq.push_back('{k, byp ? cyc : cyc + 1, dr, rb, d});
    end
    if (flush) begin
      m_wen_reg[k] = 1'b0;
      m_starve[k]  = 1'b0;
      for (int i = 0; i < NREQ; i++) m_wait[k][i] = 0;
    end else begin
      m_wen_reg[k] = (g >= 0) && dr != 0 && rb != 0 && !byp;
      m_starve[k]  = f;
      if (g >= 0) m_rr[k] = (g + 1) % NREQ;
      for (int i = 0; i < NREQ; i++)
        m_wait[k][i] = (req_valid[i] && i != g) ? ((m_wait[k][i] < 255) ? m_wait[k][i] + 1 : 255) : 0;
    end
  endtask

  task automatic settle();
    #1;
    model_step(0);
    model_step(1);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Monitor: match each presented write against the oldest queued write for that instance.
  task automatic mon(input int k);
    int idx;
    idx = -1;
    for (int i = 0; i < eq.size(); i++)
      if (idx < 0 && eq[i].inst == k) idx = i;
    if (wen[k]) begin
      if (idx < 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write[%0d]: WP1_Wen=1 at cycle %0d, required 0", k, cyc);
      end else begin
        chk($sformatf("write_cycle[%0d]", k), 32'(cyc), 32'(eq[idx].cyc));
        chk($sformatf("WP1_DRindex[%0d]", k), 32'(wdr[k]), 32'(eq[idx].dr));
        chk($sformatf("WP1_ROBEN[%0d]", k), 32'(wrob[k]), 32'(eq[idx].rob));
        chk($sformatf("WP1_Data[%0d]", k), wdata[k], eq[idx].data);
        eq.delete(idx);
      end
    end else if (idx >= 0 && eq[idx].cyc <= cyc) begin
      n_checks++;
      n_fail++;
      $display("FAIL missing_write[%0d]: WP1_Wen=0 at cycle %0d, required 1", k, cyc);
      eq.delete(idx);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        mon(0);
        mon(1);
      end
    end
  end

  initial begin
    rst         = 1'b1;
    flush       = 1'b0;
    req_valid   = '0;
    req_DRindex = '0;
    req_ROBEN   = '0;
    req_Data    = '0;
    model_reset();
    #2;
    for (int k = 0; k < 2; k++) begin
      chk("reset_ready", 32'(ready[k]), 32'd0);
      chk("reset_wen", 32'(wen[k]), 32'd0);
      chk("reset_dr", 32'(wdr[k]), 32'd0);
      chk("reset_rob", 32'(wrob[k]), 32'd0);
      chk("reset_data", wdata[k], 32'd0);
      chk("reset_starve", 32'(starve[k]), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Round robin: every requester valid every cycle, DRindex = i+1.
    for (int i = 0; i < NREQ; i++) set_req(i, 5'(i + 1), 5'(i + 1), 32'hA000 + 32'(i));
    for (int c = 0; c < 8; c++) begin
      req_valid = 4'hF;
      settle();
      chk("rr_grant", 32'(ready[0]), 32'd1 << (c % 4));
      if (c < 4) chk("forced_grant", 32'(ready[1]), 32'(seq_s[c]));
      if (c == 3) chk("starve_after_forced", 32'(starve[1]), 32'd1);
      next();
    end
    req_valid = '0;
    repeat (2) begin settle(); next(); end

    // Zero destination: consumed, no write.
    set_req(1, 5'd0, 5'd3, 32'h1111_1111);
    req_valid = 4'b0010;
    settle();
    chk("zero_dest_ready", 32'(ready[0]), 32'd2);
    next();
    req_valid = '0;
    settle();
    chk("zero_dest_wen", 32'(wen[0]), 32'd0);
    next();

    // Zero tag: consumed, no write.
    set_req(2, 5'd5, 5'd0, 32'h2222_2222);
    req_valid = 4'b0100;
    settle();
    chk("zero_tag_ready", 32'(ready[0]), 32'd4);
    next();
    req_valid = '0;
    settle();
    chk("zero_tag_wen", 32'(wen[0]), 32'd0);
    next();

    // Flush in the same cycle as a request: no grant, no write.
    set_req(0, 5'd7, 5'd1, 32'h0000_DEAD);
    req_valid = 4'b0001;
    flush     = 1'b1;
    settle();
    chk("flush_ready0", 32'(ready[0]), 32'd0);
    chk("flush_ready1", 32'(ready[1]), 32'd0);
    next();
    flush     = 1'b0;
    req_valid = '0;
    settle();
    chk("flush_wen", 32'(wen[0]), 32'd0);
    next();

    // Single requester.
    set_req(0, 5'd9, 5'd2, 32'h0000_1234);
    req_valid = 4'b0001;
    settle();
`ifdef REGFILE_WP_BYPASS_EN
    chk("single_wen", 32'(wen[0]), 32'd1);
    chk("single_data", wdata[0], 32'h0000_1234);
`endif
    next();
    req_valid = '0;
    settle();
`ifndef REGFILE_WP_BYPASS_EN
    chk("single_wen", 32'(wen[0]), 32'd1);
    chk("single_data", wdata[0], 32'h0000_1234);
`endif
    next();
    settle();
    next();

    // Asynchronous reset in the middle of a transfer.
    for (int i = 0; i < NREQ; i++) set_req(i, 5'(i + 1), 5'(i + 1), 32'hB000 + 32'(i));
    req_valid = 4'hF;
    settle();
    #1;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("midreset_wen", 32'(wen[k]), 32'd0);
      chk("midreset_ready", 32'(ready[k]), 32'd0);
    end
    model_reset();
    next();
    rst = 1'b0;
    settle();
    chk("first_grant_after_reset0", 32'(ready[0]), 32'd1);
    chk("first_grant_after_reset1", 32'(ready[1]), 32'd1);
    next();

    // Randomised traffic with occasional flushes and zero fields.
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NREQ; i++)
        set_req(i, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), $urandom);
      req_valid = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      flush     = ($urandom_range(0, 15) == 0);
      settle();
      next();
    end
    flush     = 1'b0;
    req_valid = '0;
    repeat (3) begin settle(); next(); end
    chk("queue_empty", 32'(eq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
